// File: rtl/shift_pkg.sv
// Shared definitions for the barrel shifter: mode encodings and default operand width.
package shift_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_SAR = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational multi-mode barrel shifter built as log2(WIDTH) conditional shift stages.
module barrel_shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   s,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] x;

    // Stage k shifts by 2**k when bit k of the amount is set; the stages compose to any amount.
    always_comb begin
        x = a;
        for (int k = 0; k < SHW; k++) begin
            if (s[k]) begin
                case (mode)
                    MODE_SHL: x = x << (1 << k);
                    MODE_SHR: x = x >> (1 << k);
                    MODE_SAR: x = WIDTH'($signed(x) >>> (1 << k));
                    MODE_ROL: x = (x << (1 << k)) | (x >> (WIDTH - (1 << k)));
                    default:  x = x;
                endcase
            end
        end
        y = x;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Two-stage handshaked pipeline around barrel_shift_core: S1 captures the request,
// S2 holds the shifted result and zero flag; op_count tallies accepted requests.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNTW-1:0]  op_count
);

    logic             v1;
    logic [WIDTH-1:0] d1;
    logic [SHW-1:0]   sh1;
    logic [1:0]       m1;
    logic             v2;
    logic             ready1;
    logic             ready2;
    logic             accept;
    logic [WIDTH-1:0] core_y;

    // Handshake: a transfer happens on a rising edge where valid && ready; a stage may
    // load whenever it is empty or its contents leave in the same cycle. in_ready never
    // depends on in_valid, and out_valid never depends on out_ready.
    assign ready2    = !v2 || out_ready;
    assign ready1    = !v1 || ready2;
    assign in_ready  = ready1;
    assign accept    = in_valid && ready1;
    assign out_valid = v2;

    barrel_shift_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .a    (d1),
        .s    (sh1),
        .mode (m1),
        .y    (core_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            d1       <= '0;
            sh1      <= '0;
            m1       <= '0;
            v2       <= 1'b0;
            out_data <= '0;
            out_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (ready1) begin
                v1 <= accept;
                if (accept) begin
                    d1  <= in_data;
                    sh1 <= in_shamt;
                    m1  <= in_mode;
                end
            end
            // Result registers only move on a real transfer so a stalled or idle
            // output keeps its last value.
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    out_data <= core_y;
                    out_zero <= (core_y == '0);
                end
            end
            if (accept) begin
                op_count <= op_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: behavioural queue model with per-cycle
// compare, directed vectors, backpressure, mid-operation reset and counter wrap.
module tb_barrel_shift_pipe;
    import shift_pkg::*;

    localparam int W       = 8;
    localparam int SW      = 3;
    localparam int TB_CNTW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic [SW-1:0]   in_shamt = '0;
    logic [1:0]      in_mode = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic            out_zero;
    logic [TB_CNTW-1:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    barrel_shift_pipe #(
        .WIDTH (W),
        .SHW   (SW),
        .CNTW  (TB_CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .op_count  (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each result bit picked from its source bit by the mode's rule.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic [W-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00: begin src = i - s; r[i] = (src >= 0) ? a[src] : 1'b0; end
                2'b01: begin src = i + s; r[i] = (src < W) ? a[src] : 1'b0; end
                2'b10: begin src = i + s; r[i] = (src < W) ? a[src] : a[W-1]; end
                default: begin src = (i - s + W) % W; r[i] = a[src]; end
            endcase
        end
        return r;
    endfunction

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    int           stg_q[$];
    int           acc_cnt   = 0;
    bit           rst_seen  = 1'b0;
    bit           live      = 1'b0;

    always @(posedge clk) begin
        bit exp_rdy;
        bit acc;
        if (rst) begin
            exp_q.delete();
            stg_q.delete();
            acc_cnt  = 0;
            rst_seen = 1'b1;
            live     = 1'b1;
        end else if (live) begin
            rst_seen = 1'b0;
            exp_rdy  = (exp_q.size() < 2) || out_ready;
            acc      = in_valid && exp_rdy;
            if (stg_q.size() > 0 && stg_q[0] == 2 && out_ready) begin
                void'(exp_q.pop_front());
                void'(stg_q.pop_front());
            end
            if (stg_q.size() > 0 && stg_q[0] == 1) stg_q[0] = 2;
            if (acc) begin
                exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_mode));
                stg_q.push_back(1);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (live) begin
            ev = (stg_q.size() > 0) && (stg_q[0] == 2);
            check("out_valid", 32'(out_valid), 32'(ev));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            check("op_count", 32'(op_count), 32'(acc_cnt % (1 << TB_CNTW)));
            if (ev) begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                check("out_zero", 32'(out_zero), 32'(exp_q[0] == '0));
            end
            if (rst_seen) begin
                check("rst_out_data", 32'(out_data), 32'h0);
                check("rst_out_zero", 32'(out_zero), 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("send_timeout", 32'(guard < 50), 32'h1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 20) begin
            step();
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepts;
        bit prev_stall;
        repeat (3) step();
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_op_count", 32'(op_count), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);

        check("ref_shl_18_3", 32'(ref_shift(8'h18, 3, 2'b00)), 32'hC0);
        check("ref_sar_90_2", 32'(ref_shift(8'h90, 2, 2'b10)), 32'hE4);
        check("ref_shr_90_2", 32'(ref_shift(8'h90, 2, 2'b01)), 32'h24);
        check("ref_rol_81_1", 32'(ref_shift(8'h81, 1, 2'b11)), 32'h03);
        check("ref_shl_18_5", 32'(ref_shift(8'h18, 5, 2'b00)), 32'h00);
        check("ref_sar_18_0", 32'(ref_shift(8'h18, 0, 2'b10)), 32'h18);

        // First request: captured at the edge inside send, result visible one edge later.
        out_ready = 1'b1;
        send(8'h18, 3'd3, MODE_SHL);
        check("first_not_yet_valid", 32'(out_valid), 32'h0);
        step();
        check("first_out_valid", 32'(out_valid), 32'h1);
        check("first_out_data", 32'(out_data), 32'hC0);
        check("first_out_zero", 32'(out_zero), 32'h0);
        check("first_op_count", 32'(op_count), 32'h1);
        drain();

        send(8'h90, 3'd2, MODE_SAR);
        send(8'h90, 3'd2, MODE_SHR);
        send(8'h81, 3'd1, MODE_ROL);
        send(8'h18, 3'd5, MODE_SHL);
        drain();
        send(8'h18, 3'd5, MODE_SHL);
        step();
        check("zero_result_flag", 32'(out_zero), 32'h1);
        drain();

        for (int m = 0; m < 4; m++)
            for (int s = 0; s < 8; s++)
                send(8'h18, 3'(s), 2'(m));
        drain();

        // Backpressure from an empty pipe: exactly two requests fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepts   = 0;
        for (int c = 0; c < 4; c++) begin
            in_data  = 8'(8'h31 + c);
            in_shamt = 3'(c + 1);
            in_mode  = 2'(c);
            if (in_ready) accepts++;
            step();
        end
        check("stall_accepts", 32'(accepts), 32'h2);
        check("stall_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        drain();

        // Random traffic; a request is held until accepted.
        prev_stall = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!prev_stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_shamt = 3'($urandom_range(0, 7));
                in_mode  = 2'($urandom_range(0, 3));
            end
            out_ready  = ($urandom_range(0, 3) != 0);
            prev_stall = in_valid && !in_ready;
            step();
        end
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(8'hA5, 3'd1, MODE_SHL);
        send(8'h5A, 3'd2, MODE_ROL);
        check("pre_rst_full", 32'(in_ready), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        check("midrst_op_count", 32'(op_count), 32'h0);

        // Counter wrap.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < (1 << TB_CNTW) - 1; c++) begin
            in_data  = 8'($urandom);
            in_shamt = 3'($urandom_range(0, 7));
            in_mode  = 2'($urandom_range(0, 3));
            step();
        end
        check("count_all_ones", 32'(op_count), 32'((1 << TB_CNTW) - 1));
        step();
        check("count_wrap", 32'(op_count), 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
